// File: rtl/md_pkg.sv
// Shared encodings and sizing for the iterative multiply/divide unit.
package md_pkg;

  localparam logic [2:0] MD_MULT  = 3'b000;
  localparam logic [2:0] MD_MULTU = 3'b001;
  localparam logic [2:0] MD_DIV   = 3'b010;
  localparam logic [2:0] MD_DIVU  = 3'b011;
  localparam logic [2:0] MD_MTHI  = 3'b100;
  localparam logic [2:0] MD_MTLO  = 3'b101;

  typedef enum logic [1:0] {IDLE, CALC, FIX} md_state_e;

  function automatic int md_cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/md_abs_neg.sv
// Conditional two's-complement negate: magnitudes on the way in, sign fix on the way out.
module md_abs_neg
  import md_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [W-1:0] val_i,
  input  logic         neg_i,
  output logic [W-1:0] res_o
);

  assign res_o = neg_i ? (~val_i + W'(1)) : val_i;

endmodule

// File: rtl/md_unit.sv
// Iterative MIPS multiply/divide unit owning HI/LO; shift-add multiply, restoring divide.
// Optional MD_EARLY_OUT_EN: multiplies stop once the remaining multiplier bits are zero.
module md_unit
  import md_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             div_zero_o
);

  localparam int CNT_W = md_cnt_w(WIDTH);

  md_state_e          state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplr_q;
  logic               is_div_q, pneg_q, rneg_q;
  logic               busy_q, done_q, dz_q;
  logic [WIDTH-1:0]   hi_q, lo_q;

  logic               signed_op, a_neg, b_neg, last_iter;
  logic [WIDTH-1:0]   abs_a, abs_b, quo_fix, rem_fix;
  logic [2*WIDTH-1:0] prod_fix, mul_sum, div_next;
  logic [WIDTH:0]     diff;

  assign signed_op = ~op_i[0];
  assign a_neg     = signed_op & a_i[WIDTH-1];
  assign b_neg     = signed_op & b_i[WIDTH-1];

  md_abs_neg #(.W(WIDTH))   u_abs_a (.val_i(a_i), .neg_i(a_neg), .res_o(abs_a));
  md_abs_neg #(.W(WIDTH))   u_abs_b (.val_i(b_i), .neg_i(b_neg), .res_o(abs_b));
  md_abs_neg #(.W(2*WIDTH)) u_prod  (.val_i(acc_q), .neg_i(pneg_q), .res_o(prod_fix));
  md_abs_neg #(.W(WIDTH))   u_quo   (.val_i(acc_q[WIDTH-1:0]), .neg_i(pneg_q), .res_o(quo_fix));
  md_abs_neg #(.W(WIDTH))   u_rem   (.val_i(acc_q[2*WIDTH-1:WIDTH]), .neg_i(rneg_q), .res_o(rem_fix));

  // Multiplicand shifts left each cycle, so an early exit needs no realignment.
  // Divide keeps {remainder, dividend/quotient} in acc and shifts it left.
  always_comb begin
    mul_sum  = acc_q + (mplr_q[0] ? mcand_q : '0);
    diff     = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, mplr_q};
    div_next = diff[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                           : {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    acc_d    = is_div_q ? div_next : mul_sum;
    last_iter = (cnt_q == CNT_W'(1));
`ifdef MD_EARLY_OUT_EN
    if (!is_div_q && (mplr_q[WIDTH-1:1] == '0)) last_iter = 1'b1;
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplr_q   <= '0;
      is_div_q <= 1'b0;
      pneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            case (op_i)
              MD_MULT, MD_MULTU: begin
                state_q  <= CALC;
                busy_q   <= 1'b1;
                dz_q     <= 1'b0;
                is_div_q <= 1'b0;
                acc_q    <= '0;
                mcand_q  <= {{WIDTH{1'b0}}, abs_a};
                mplr_q   <= abs_b;
                cnt_q    <= CNT_W'(WIDTH);
                pneg_q   <= a_neg ^ b_neg;
                rneg_q   <= 1'b0;
              end
              MD_DIV, MD_DIVU: begin
                busy_q   <= 1'b1;
                dz_q     <= 1'b0;
                is_div_q <= 1'b1;
                mplr_q   <= abs_b;
                cnt_q    <= CNT_W'(WIDTH);
                if (b_i == '0) begin
                  // Raw a into HI, all ones into LO; FIX passes them through unsigned.
                  state_q <= FIX;
                  acc_q   <= {a_i, {WIDTH{1'b1}}};
                  pneg_q  <= 1'b0;
                  rneg_q  <= 1'b0;
                end else begin
                  state_q <= CALC;
                  acc_q   <= {{WIDTH{1'b0}}, abs_a};
                  pneg_q  <= a_neg ^ b_neg;
                  rneg_q  <= a_neg;
                end
              end
              MD_MTHI: begin
                hi_q   <= a_i;
                dz_q   <= 1'b0;
                done_q <= 1'b1;
              end
              MD_MTLO: begin
                lo_q   <= a_i;
                dz_q   <= 1'b0;
                done_q <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        CALC: begin
          acc_q   <= acc_d;
          mcand_q <= mcand_q << 1;
          if (!is_div_q) mplr_q <= mplr_q >> 1;
          cnt_q   <= cnt_q - CNT_W'(1);
          if (last_iter) state_q <= FIX;
        end
        FIX: begin
          hi_q    <= is_div_q ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
          lo_q    <= is_div_q ? quo_fix : prod_fix[WIDTH-1:0];
          dz_q    <= is_div_q && (mplr_q == '0);
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign hi_o       = hi_q;
  assign lo_o       = lo_q;
  assign div_zero_o = dz_q;

endmodule
